// File: rtl/compuertas_logicas.sv
// Registered basic-logic-gate unit: NOT/AND/OR/XOR/XNOR/NAND plus one
// opcode-selected gate, all captured with one cycle of latency.
module compuertas_logicas #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] Snot,
  output logic [WIDTH-1:0] Sand,
  output logic [WIDTH-1:0] Sor,
  output logic [WIDTH-1:0] Sxor,
  output logic [WIDTH-1:0] Sxnor,
  output logic [WIDTH-1:0] Snand,
  output logic [WIDTH-1:0] Ssel,
  output logic             out_valid
);

  logic [WIDTH-1:0] n_not;
  logic [WIDTH-1:0] n_and;
  logic [WIDTH-1:0] n_or;
  logic [WIDTH-1:0] n_xor;
  logic [WIDTH-1:0] n_sel;

  assign n_not = ~A;
  assign n_and = A & B;
  assign n_or  = A | B;
  assign n_xor = A ^ B;

  always_comb begin
    n_sel = '0;
    unique case (sel)
      3'd0: n_sel = n_not;
      3'd1: n_sel = n_and;
      3'd2: n_sel = n_or;
      3'd3: n_sel = n_xor;
      3'd4: n_sel = ~n_xor;
      3'd5: n_sel = ~n_and;
      3'd6: n_sel = ~n_or;
      3'd7: n_sel = '0;
    endcase
  end

  // Results hold while in_valid is low; only out_valid tracks every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      Snot      <= '0;
      Sand      <= '0;
      Sor       <= '0;
      Sxor      <= '0;
      Sxnor     <= '0;
      Snand     <= '0;
      Ssel      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Snot  <= n_not;
        Sand  <= n_and;
        Sor   <= n_or;
        Sxor  <= n_xor;
        Sxnor <= ~n_xor;
        Snand <= ~n_and;
        Ssel  <= n_sel;
      end
    end
  end

endmodule

// File: tb/tb_compuertas_logicas.sv
// Scoreboard bench: truth-table reference model drives an expectation
// queue; a monitor checks a WIDTH=4 and a WIDTH=1 instance every cycle.
module tb_compuertas_logicas;

  typedef struct {
    logic [3:0] snot, sand, sor, sxor, sxnor, snand, ssel;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [2:0] sel = '0;

  logic [3:0] Snot, Sand, Sor, Sxor, Sxnor, Snand, Ssel;
  logic       out_valid;
  logic       Snot1, Sand1, Sor1, Sxor1, Sxnor1, Snand1, Ssel1;
  logic       out_valid1;

  int ncmp = 0;
  int nmis = 0;
  exp_t q[$];
  exp_t m;

  // Truth tables indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1.
  logic [3:0] tt_sel [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                             4'b1001, 4'b0111, 4'b0001, 4'b0000};

  always #5 clk = ~clk;

  compuertas_logicas #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .sel(sel),
    .Snot(Snot), .Sand(Sand), .Sor(Sor), .Sxor(Sxor),
    .Sxnor(Sxnor), .Snand(Snand), .Ssel(Ssel),
    .out_valid(out_valid)
  );

  compuertas_logicas #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A[0]), .B(B[0]), .sel(sel),
    .Snot(Snot1), .Sand(Sand1), .Sor(Sor1), .Sxor(Sxor1),
    .Sxnor(Sxnor1), .Snand(Snand1), .Ssel(Ssel1),
    .out_valid(out_valid1)
  );

  function automatic logic [3:0] gate(
    input logic [3:0] tt, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string n, input logic [3:0] act,
                     input logic [3:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] s);
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b; sel = s;
    if (r) begin
      m = '{default: '0};
    end else begin
      m.ov = v;
      if (v) begin
        m.snot  = gate(4'b0011, a, b);
        m.sand  = gate(4'b1000, a, b);
        m.sor   = gate(4'b1110, a, b);
        m.sxor  = gate(4'b0110, a, b);
        m.sxnor = gate(4'b1001, a, b);
        m.snand = gate(4'b0111, a, b);
        m.ssel  = gate(tt_sel[s], a, b);
      end
    end
    q.push_back(m);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_valid", {3'b0, out_valid}, {3'b0, e.ov});
        chk("Snot",  Snot,  e.snot);
        chk("Sand",  Sand,  e.sand);
        chk("Sor",   Sor,   e.sor);
        chk("Sxor",  Sxor,  e.sxor);
        chk("Sxnor", Sxnor, e.sxnor);
        chk("Snand", Snand, e.snand);
        chk("Ssel",  Ssel,  e.ssel);
        chk("w1_out_valid", {3'b0, out_valid1}, {3'b0, e.ov});
        chk("w1_Snot",  {3'b0, Snot1},  {3'b0, e.snot[0]});
        chk("w1_Sand",  {3'b0, Sand1},  {3'b0, e.sand[0]});
        chk("w1_Sor",   {3'b0, Sor1},   {3'b0, e.sor[0]});
        chk("w1_Sxor",  {3'b0, Sxor1},  {3'b0, e.sxor[0]});
        chk("w1_Sxnor", {3'b0, Sxnor1}, {3'b0, e.sxnor[0]});
        chk("w1_Snand", {3'b0, Snand1}, {3'b0, e.snand[0]});
        chk("w1_Ssel",  {3'b0, Ssel1},  {3'b0, e.ssel[0]});
      end
    end
  end

  initial begin : driver
    int waited;
    m = '{default: '0};
    step(1, 0, 4'h0, 4'h0, 3'd0);
    step(1, 0, 4'h0, 4'h0, 3'd0);
    // single-bit truth table sweep
    step(0, 1, 4'h0, 4'h0, 3'd0);
    step(0, 1, 4'h0, 4'h1, 3'd1);
    step(0, 1, 4'h1, 4'h0, 3'd2);
    step(0, 1, 4'h1, 4'h1, 3'd3);
    // sel sweep with A=1,B=0
    for (int s = 0; s < 8; s++) step(0, 1, 4'h1, 4'h0, 3'(s));
    // hold with in_valid low
    step(0, 1, 4'h1, 4'h1, 3'd1);
    step(0, 0, 4'h0, 4'h0, 3'd7);
    step(0, 0, 4'h0, 4'h0, 3'd7);
    // multi-bit directed vector, checked against literal results too
    step(0, 1, 4'b1100, 4'b1010, 3'd6);
    @(posedge clk);
    #2;
    chk("dir_Sand",  Sand,  4'b1000);
    chk("dir_Sor",   Sor,   4'b1110);
    chk("dir_Sxor",  Sxor,  4'b0110);
    chk("dir_Sxnor", Sxnor, 4'b1001);
    chk("dir_Snand", Snand, 4'b0111);
    chk("dir_Snot",  Snot,  4'b0011);
    chk("dir_Ssel",  Ssel,  4'b0001);
    // reset wins over a valid input, then resume
    step(1, 1, 4'hF, 4'h3, 3'd1);
    step(0, 1, 4'h5, 4'h6, 3'd3);
    // randomized phase
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 3'($urandom));
    end
    step(0, 0, 4'h0, 4'h0, 3'd0);
    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    ncmp++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
